// File: rtl/obi_master.sv
`default_nettype none
// ============================================================================
// Module      : obi_master
// Description : Single-outstanding OBI initiator. Converts one command-port
//               request into an OBI read/write transaction and returns the
//               response on the response port.
//               Optional macro OBI_MASTER_TIMEOUT_EN adds an rvalid watchdog
//               with a stale-rvalid drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_master #(
  parameter int unsigned          ADDR_WIDTH     = 32,
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned          TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  // command port
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  // response port
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // OBI address phase
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  // OBI response phase
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  // Elaboration-time parameter sanity checks
  if (DATA_WIDTH % 8 != 0) begin : g_chk_data_width
    $error("obi_master: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("obi_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2,
    RSP         = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic                   we_q,    we_d;
  logic [BE_W-1:0]        be_q,    be_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_ok;

`ifdef OBI_MASTER_TIMEOUT_EN
  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic             stale_q, stale_d;
`endif

  // Next-state and datapath decode for the transaction FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef OBI_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
    stale_d = stale_q;
    // A stale flag swallows exactly one rvalid, in whatever state it lands
    rvalid_ok = obi_rvalid_i && !stale_q;
    if (obi_rvalid_i) begin
      stale_d = 1'b0;
    end
`else
    rvalid_ok = obi_rvalid_i;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = BASE_ADDR + cmd_addr_i;  // wraps modulo 2^ADDR_WIDTH
          we_d    = cmd_we_i;
          be_d    = cmd_be_i;
          wdata_d = cmd_wdata_i;
          state_d = REQ;
        end
      end
      REQ: begin
        // rvalid here is a responder protocol violation and is ignored
        if (obi_gnt_i) begin
          state_d = WAIT_RVALID;
`ifdef OBI_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RVALID: begin
        if (rvalid_ok) begin
          rdata_d = we_q ? '0 : obi_rdata_i;
          state_d = RSP;
`ifdef OBI_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          // Give up; the late rvalid, if it ever arrives, must be dropped
          rdata_d = '0;
          err_d   = 1'b1;
          stale_d = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef OBI_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef OBI_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stale_q <= stale_d;
`endif
    end
  end

  // Outputs come from registers or a pure state decode only
  assign cmd_ready_o = (state_q == IDLE);
  assign obi_req_o   = (state_q == REQ);
  assign rsp_valid_o = (state_q == RSP);
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign rsp_rdata_o = rdata_q;
`ifdef OBI_MASTER_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_master
// Description : Scoreboard bench for obi_master. Stimulus pushes per-command
//               responder jobs and expected responses; a responder process
//               plays the OBI target, a monitor process checks responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_master;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          BW   = DW / 8;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam int          LATE = 12;   // late rvalid, cycles after grant

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_be_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i;
  logic [AW-1:0] obi_addr_o;
  logic [BW-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o, obi_rdata_i;

  obi_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          gd;      // cycles req is held before gnt
    int          rvd;     // rvalid cycle offset from grant (>=1)
    logic [31:0] rdata;
    bit          sp;      // spurious rvalid while in REQ
    bit          to;      // responder withholds rvalid until LATE
    bit          ab;      // abandoned by reset, no response expected
    int          acc;     // cycle in which the command was presented
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } job_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  job_t job_q[$];
  rsp_t exp_q[$];
  int   time_q[$];

  int errors = 0;
  int checks = 0;
  bit rbusy = 1'b0;
  bit force_bp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s @cycle %0d: actual=event-missing/unexpected required=ok", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_err"},   rsp_err_o,   0);
    chk({tag, "_obi_req"},   obi_req_o,   0);
    chk({tag, "_obi_we"},    obi_we_o,    0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_obi_addr"},  obi_addr_o,  0);
    chk({tag, "_obi_be"},    obi_be_o,    0);
    chk({tag, "_obi_wdata"}, obi_wdata_o, 0);
  endtask

  // Present one command and register what the responder and monitor expect
  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int gd, input int rvd,
                       input logic [31:0] rd, input bit to, input bit ab,
                       input bit sp, output int acc);
    job_t j;
    rsp_t e;
    int   n = 0;
    while (cmd_ready_o !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) fail("cmd_ready_wait");
    j.gd = gd; j.rvd = rvd; j.rdata = rd; j.sp = sp; j.to = to; j.ab = ab;
    j.acc = cyc; j.addr = BASE + a; j.we = we; j.be = be; j.wdata = wd;
    job_q.push_back(j);
    if (!ab) begin
      e.rdata = we ? 32'h0 : rd;
      e.err   = 1'b0;
`ifdef OBI_MASTER_TIMEOUT_EN
      if (to) begin
        e.rdata = 32'h0;
        e.err   = 1'b1;
      end
`endif
      exp_q.push_back(e);
    end
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_be_i = be; cmd_wdata_i = wd;
    acc = cyc;
    tick();
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_addr_i  = $urandom;
    cmd_be_i    = 4'($urandom);
    cmd_wdata_i = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || job_q.size() != 0 || time_q.size() != 0 || rbusy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail("drain_timeout");
  endtask

  // OBI responder: serves jobs in order, checks the address phase
  initial begin
    job_t j;
    int   g;
    int   ws = 0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0;
    forever begin
      tick();
      obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = $urandom;
      if (rstn_i === 1'b1 && obi_req_o === 1'b1) begin
        if (job_q.size() == 0) begin
          fail("unexpected_req");
        end else begin
          rbusy = 1'b1;
          j = job_q.pop_front();
          if (j.acc + 1 >= ws) chk("req_latency", cyc, j.acc + 1);
          for (int k = 0; k <= j.gd; k++) begin
            if (k > 0) tick();
            chk("req_held", obi_req_o,   1);
            chk("obi_addr", obi_addr_o,  j.addr);
            chk("obi_we",   obi_we_o,    j.we);
            chk("obi_be",   obi_be_o,    j.be);
            chk("obi_wdata",obi_wdata_o, j.wdata);
            obi_rvalid_i = j.sp && (k < j.gd);
            obi_rdata_i  = obi_rvalid_i ? 32'hDEAD_BEEF : $urandom;
            obi_gnt_i    = (k == j.gd);
          end
          g = cyc;
          tick();
          obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
          chk("req_drop", obi_req_o, 0);
          if (j.to) begin
`ifdef OBI_MASTER_TIMEOUT_EN
            time_q.push_back(g + TO + 1);
`endif
            while (cyc < g + LATE) begin
              tick();
              obi_rvalid_i = 1'b0;
            end
            obi_rvalid_i = 1'b1; obi_rdata_i = j.rdata;
`ifndef OBI_MASTER_TIMEOUT_EN
            time_q.push_back(cyc + 1);
`endif
          end else begin
            while (cyc < g + j.rvd) begin
              tick();
              obi_rvalid_i = 1'b0;
            end
            obi_rvalid_i = 1'b1; obi_rdata_i = j.rdata;
            if (!j.ab) time_q.push_back(cyc + 1);
          end
          ws = cyc + 1;
          rbusy = 1'b0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard, checks timing/stability, backpressures
  initial begin
    rsp_t        e;
    int          t;
    int          hold = 0;
    bit          active = 1'b0;
    bit          hs = 1'b0;
    logic [31:0] cap_d;
    logic        cap_e;
    rsp_ready_i = 1'b0;
    forever begin
      tick();
      if (rstn_i !== 1'b1) begin
        active = 1'b0; hs = 1'b0; rsp_ready_i = 1'b0;
        continue;
      end
      if (hs) begin
        chk("rsp_drop",        rsp_valid_o, 0);
        chk("ready_after_rsp", cmd_ready_o, 1);
        hs = 1'b0;
        active = 1'b0;
      end
      if (rsp_valid_o === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          if (exp_q.size() == 0 || time_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            t = time_q.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_err",   rsp_err_o,   e.err);
            chk("rsp_cycle", cyc,         t);
          end
          cap_d = rsp_rdata_o;
          cap_e = rsp_err_o;
          hold  = force_bp ? 5 : $urandom_range(0, 2);
          force_bp = 1'b0;
        end else begin
          chk("rsp_rdata_stable", rsp_rdata_o, cap_d);
          chk("rsp_err_stable",   rsp_err_o,   cap_e);
        end
        chk("cmd_ready_in_rsp", cmd_ready_o, 0);
        if (hold > 0) begin
          rsp_ready_i = 1'b0;
          hold--;
        end else begin
          rsp_ready_i = 1'b1;
          hs = 1'b1;
        end
      end else begin
        rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int acc;
    rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_addr_i = '0; cmd_be_i = '0; cmd_wdata_i = '0;
    repeat (3) tick();
    chk_reset_values("reset");
    rstn_i = 1'b1;
    tick();

    // zero-wait read; cmd 0x20 + base 0xFFFF_FFF0 wraps to 0x10
    issue(1'b0, 32'h20, 4'hF, 32'h0, 0, 1, 32'hCAFE_F00D, 0, 0, 0, acc);
    // write with 3-cycle grant delay
    issue(1'b1, 32'h4, 4'b0011, 32'hA5A5_A5A5, 3, 2, 32'h1111_2222, 0, 0, 0, acc);
    // read with spurious rvalid while in REQ
    issue(1'b0, 32'h100, 4'hF, 32'h0, 2, 3, 32'h0BAD_CAFE, 0, 0, 1, acc);
    drain();

    // backpressure on the response
    force_bp = 1'b1;
    issue(1'b0, 32'h40, 4'hF, 32'h0, 1, 1, 32'h1357_9BDF, 0, 0, 0, acc);
    issue(1'b0, 32'h44, 4'hF, 32'h0, 0, 1, 32'h2468_ACE0, 0, 0, 0, acc);
    drain();

    // reset while waiting for rvalid; rvalid then arrives after reset
    issue(1'b1, 32'h80, 4'hC, 32'h7777_8888, 0, 5, 32'hFEED_FACE, 0, 1, 0, acc);
    while (cyc < acc + 3) tick();
    rstn_i = 1'b0;
    tick();
    chk_reset_values("midreset");
    rstn_i = 1'b1;
    repeat (6) tick();
    chk("post_reset_rsp_valid", rsp_valid_o, 0);
    chk("post_reset_cmd_ready", cmd_ready_o, 1);
    drain();

    // rvalid withheld: timeout with the macro, long wait without it
    issue(1'b0, 32'h200, 4'hF, 32'h0, 0, 1, 32'h1234_5678, 1, 0, 0, acc);
    issue(1'b0, 32'h204, 4'hF, 32'h0, 1, 2, 32'h600D_F00D, 0, 0, 0, acc);
    drain();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int gd;
      gd = $urandom_range(0, 3);
      issue(1'($urandom), $urandom, 4'($urandom), $urandom, gd,
            $urandom_range(1, 4), $urandom, 0, 0, (gd > 0) && 1'($urandom), acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: actual=no-finish required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
